// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : alu_seq_pkg
//  Desc    : Shared types and constants for the ALU command sequencer.
//  Rev     : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

    // FSM state encoding; the value is exported on the phase port for LEDs
    typedef enum logic [2:0] {
        ST_LOAD_A  = 3'd0,
        ST_LOAD_B  = 3'd1,
        ST_LOAD_OP = 3'd2,
        ST_EXEC    = 3'd3,
        ST_SHOW    = 3'd4
    } seq_state_e;

    // Bit positions inside the packed {neg, cero, carry, des} flag word
    localparam int FLAG_NEG   = 3;
    localparam int FLAG_CERO  = 2;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_DES   = 0;

    // Width of the ALU operation select
    localparam int MODE_W = 4;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_cmd_sequencer_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module  : btn_debounce
//  Desc    : 2-FF synchronizer, counter debouncer and rising-edge pulse for
//            one raw push button.
//  Rev     : 1.0  initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse_q;
    logic             pulse_d;

    // Count consecutive synchronized samples that disagree with the accepted
    // level; the level flips on the DEBOUNCE_CYCLES-th one. Any agreeing
    // sample restarts the count, so short glitches never get through.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        pulse_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                pulse_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, debounce state and one-cycle press pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : alu_cmd_sequencer
//  Desc    : Button-stepped front-end that loads operands and mode from the
//            switch bank, drives the ALU, and captures its result and flags.
//  Rev     : 1.0  initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     sw,
    input  logic                 btn_next,
    input  logic                 btn_clr,
    output logic [WIDTH-1:0]     alu_in1,
    output logic [WIDTH-1:0]     alu_in2,
    output logic [MODE_W-1:0]    alu_mode,
    input  logic [2*WIDTH-1:0]   alu_num,
    input  logic                 alu_neg,
    input  logic                 alu_cero,
    input  logic                 alu_carry,
    input  logic                 alu_des,
    output logic [2*WIDTH-1:0]   res_num,
    output logic [3:0]           res_flags,
    output logic                 res_valid,
    output logic [2:0]           phase
);

    localparam int SETTLE_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

    logic w_next_pulse;
    logic w_clr_pulse;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_next),
        .pulse_o (w_next_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_clr),
        .pulse_o (w_clr_pulse)
    );

    // Mode comes from the low switches; narrow banks are zero-extended
    logic [MODE_W-1:0] w_sw_mode;
    generate
        if (WIDTH >= MODE_W) begin : g_mode_wide
            assign w_sw_mode = sw[MODE_W-1:0];
        end else begin : g_mode_narrow
            assign w_sw_mode = {{(MODE_W-WIDTH){1'b0}}, sw};
        end
    endgenerate

    seq_state_e          state_q, state_d;
    logic [WIDTH-1:0]    in1_q, in1_d;
    logic [WIDTH-1:0]    in2_q, in2_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [2*WIDTH-1:0]  num_q, num_d;
    logic [3:0]          flags_q, flags_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [3:0]          w_alu_flags;

    // Pack the ALU flag inputs into the display flag word
    always_comb begin
        w_alu_flags             = '0;
        w_alu_flags[FLAG_NEG]   = alu_neg;
        w_alu_flags[FLAG_CERO]  = alu_cero;
        w_alu_flags[FLAG_CARRY] = alu_carry;
        w_alu_flags[FLAG_DES]   = alu_des;
    end

    // Next-state and register updates; clear beats advance in the same cycle
    always_comb begin
        state_d  = state_q;
        in1_d    = in1_q;
        in2_d    = in2_q;
        mode_d   = mode_q;
        num_d    = num_q;
        flags_d  = flags_q;
        settle_d = settle_q;
        if (w_clr_pulse) begin
            state_d  = ST_LOAD_A;
            in1_d    = '0;
            in2_d    = '0;
            mode_d   = '0;
            num_d    = '0;
            flags_d  = '0;
            settle_d = '0;
        end else begin
            case (state_q)
                ST_LOAD_A: begin
                    if (w_next_pulse) begin
                        in1_d   = sw;
                        state_d = ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    if (w_next_pulse) begin
                        in2_d   = sw;
                        state_d = ST_LOAD_OP;
                    end
                end
                ST_LOAD_OP: begin
                    if (w_next_pulse) begin
                        mode_d   = w_sw_mode;
                        settle_d = SETTLE_LOAD;
                        state_d  = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Advance presses are ignored while the ALU settles
                    if (settle_q == '0) begin
                        num_d   = alu_num;
                        flags_d = w_alu_flags;
                        state_d = ST_SHOW;
                    end else begin
                        settle_d = settle_q - 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (w_next_pulse) begin
                        state_d = ST_LOAD_A;
                    end
                end
                default: begin
                    state_d = ST_LOAD_A;
                end
            endcase
        end
    end

    // State, operand, mode, settle counter and capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LOAD_A;
            in1_q    <= '0;
            in2_q    <= '0;
            mode_q   <= '0;
            num_q    <= '0;
            flags_q  <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            mode_q   <= mode_d;
            num_q    <= num_d;
            flags_q  <= flags_d;
            settle_q <= settle_d;
        end
    end

    assign alu_in1   = in1_q;
    assign alu_in2   = in2_q;
    assign alu_mode  = mode_q;
    assign res_num   = num_q;
    assign res_flags = flags_q;
    assign res_valid = (state_q == ST_SHOW);
    assign phase     = state_q;

endmodule : alu_cmd_sequencer
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_alu_cmd_sequencer
//  Desc    : Directed self-checking bench for alu_cmd_sequencer with a small
//            behavioural ALU (mode 0 = add, mode 1 = subtract).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] sw;
    logic             btn_next;
    logic             btn_clr;
    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic [3:0]       alu_mode;
    logic [7:0]       alu_num;
    logic             alu_neg, alu_cero, alu_carry, alu_des;
    logic [7:0]       res_num;
    logic [3:0]       res_flags;
    logic             res_valid;
    logic [2:0]       phase;

    int n_checks = 0;
    int n_fail   = 0;

    alu_cmd_sequencer #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (4),
        .SETTLE_CYCLES   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .btn_next  (btn_next),
        .btn_clr   (btn_clr),
        .alu_in1   (alu_in1),
        .alu_in2   (alu_in2),
        .alu_mode  (alu_mode),
        .alu_num   (alu_num),
        .alu_neg   (alu_neg),
        .alu_cero  (alu_cero),
        .alu_carry (alu_carry),
        .alu_des   (alu_des),
        .res_num   (res_num),
        .res_flags (res_flags),
        .res_valid (res_valid),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: add sets carry from bit 4; subtract flags a borrow
    // as both neg and carry and returns the 8-bit two's-complement result.
    always_comb begin
        alu_num   = '0;
        alu_neg   = 1'b0;
        alu_carry = 1'b0;
        alu_des   = 1'b0;
        case (alu_mode)
            4'd0: begin
                alu_num   = {4'b0, alu_in1} + {4'b0, alu_in2};
                alu_carry = alu_num[4];
            end
            4'd1: begin
                alu_num   = {4'b0, alu_in1} - {4'b0, alu_in2};
                alu_neg   = (alu_in1 < alu_in2);
                alu_carry = (alu_in1 < alu_in2);
            end
            default: alu_num = '0;
        endcase
        alu_cero = (alu_num == 8'd0);
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Clean press: held 10 cycles, then released long enough to settle
    task automatic press_next(input logic [WIDTH-1:0] val);
        @(negedge clk);
        sw       = val;
        btn_next = 1'b1;
        repeat (10) @(negedge clk);
        btn_next = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    // Bounded wait for a phase; a timeout shows up as a failed comparison
    task automatic wait_phase(input logic [2:0] tgt, input string tag);
        for (int i = 0; i < 30 && phase != tgt; i++) @(negedge clk);
        chk(tag, 16'(phase), 16'(tgt));
    endtask

    initial begin
        rst_n    = 1'b0;
        sw       = '0;
        btn_next = 1'b0;
        btn_clr  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_held_phase", 16'(phase), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in1",   16'(alu_in1),   16'd0);
        chk("rst_in2",   16'(alu_in2),   16'd0);
        chk("rst_mode",  16'(alu_mode),  16'd0);
        chk("rst_num",   16'(res_num),   16'd0);
        chk("rst_flags", 16'(res_flags), 16'd0);
        chk("rst_valid", 16'(res_valid), 16'd0);
        repeat (20) @(negedge clk);
        chk("idle_phase", 16'(phase), 16'd0);

        // 5 + 1 in add mode
        press_next(4'd5);
        chk("add_in1", 16'(alu_in1), 16'd5);
        chk("add_ph1", 16'(phase),   16'd1);
        press_next(4'd1);
        chk("add_in2", 16'(alu_in2), 16'd1);
        @(negedge clk);
        sw       = 4'd0;
        btn_next = 1'b1;
        wait_phase(3'd3, "add_exec");
        chk("add_mode",       16'(alu_mode),  16'd0);
        chk("add_exec_valid", 16'(res_valid), 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("add_phase", 16'(phase),     16'd4);
        chk("add_num",   16'(res_num),   16'd6);
        chk("add_flags", 16'(res_flags), 16'b0000);
        chk("add_valid", 16'(res_valid), 16'd1);
        repeat (6) @(negedge clk);
        btn_next = 1'b0;
        repeat (12) @(negedge clk);
        chk("show_norepeat", 16'(phase), 16'd4);
        press_next(4'd0);
        chk("ret_phase", 16'(phase),     16'd0);
        chk("ret_valid", 16'(res_valid), 16'd0);
        chk("ret_hold",  16'(res_num),   16'd6);

        // 4 - 5 in subtract mode: -1, negative with borrow
        press_next(4'd4);
        press_next(4'd5);
        press_next(4'd1);
        wait_phase(3'd4, "sub_show");
        chk("sub_num",   16'(res_num),   16'h00FF);
        chk("sub_flags", 16'(res_flags), 16'b1010);
        press_next(4'd0);
        chk("sub_ret", 16'(phase), 16'd0);

        // 3-cycle glitch is rejected; a clean press advances exactly once
        @(negedge clk);
        sw       = 4'd4;
        btn_next = 1'b1;
        repeat (3) @(negedge clk);
        btn_next = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_phase", 16'(phase),   16'd0);
        chk("glitch_in1",   16'(alu_in1), 16'd4);
        press_next(4'd4);
        chk("clean_phase", 16'(phase),   16'd1);
        chk("clean_in1",   16'(alu_in1), 16'd4);
        press_next(4'd5);
        chk("loadop_phase", 16'(phase), 16'd2);

        // Clear and advance pressed together in LOAD_OP: clear wins
        @(negedge clk);
        btn_next = 1'b1;
        btn_clr  = 1'b1;
        repeat (10) @(negedge clk);
        chk("clr_phase", 16'(phase),     16'd0);
        chk("clr_in1",   16'(alu_in1),   16'd0);
        chk("clr_in2",   16'(alu_in2),   16'd0);
        chk("clr_valid", 16'(res_valid), 16'd0);
        chk("clr_num",   16'(res_num),   16'd0);
        btn_next = 1'b0;
        btn_clr  = 1'b0;
        repeat (12) @(negedge clk);

        // Reset during EXEC aborts the capture asynchronously
        press_next(4'd3);
        press_next(4'd2);
        @(negedge clk);
        sw       = 4'd0;
        btn_next = 1'b1;
        wait_phase(3'd3, "rst_exec");
        rst_n    = 1'b0;
        btn_next = 1'b0;
        #1;
        chk("arst_phase", 16'(phase),     16'd0);
        chk("arst_in1",   16'(alu_in1),   16'd0);
        chk("arst_num",   16'(res_num),   16'd0);
        chk("arst_valid", 16'(res_valid), 16'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_phase", 16'(phase),   16'd0);
        chk("post_num",   16'(res_num), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_cmd_sequencer
`default_nettype wire
